clk_div_ctrl: RTL and testbench

Programmable clock-divider controller that generates a registered, glitch-free divided clock (clk_out) from the master clock.
- Sequences start/stop of the divided clock.
- Accepts divide-ratio reconfiguration over a valid/ready handshake and applies it only at a period boundary, so frequency changes never produce runt pulses.
- Sits between the master clock buffer and downstream divided-clock consumers.
- Provides a phase-reference tick so benches can check frequency and phase against the master clock.

---
 rtl/clk_div_ctrl.sv | 169 ++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Programmable clock-divider controller. Produces a register-driven,
// glitch-free divided clock from the master clock, sequences its start and
// stop, and accepts divide-ratio changes over a valid/ready handshake. Ratio
// changes take effect only at a period boundary, so no runt pulses appear on
// clk_out when the frequency changes.
//
// Waveform for ratio N: the high phase lasts ceil(N/2) cycles and the low phase
// lasts floor(N/2) cycles, for a period of exactly N master-clock cycles.
//
// Ports:
//   clk        master clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   en         run request; low stops the divided clock at the next boundary
//   cfg_valid  a new divide ratio is offered on cfg_div
//   cfg_div    requested divide ratio (legal range 2 .. 2^WIDTH-1)
//   cfg_ready  a ratio can be accepted this cycle (no ratio pending)
//   clk_out    divided clock
//   tick       one-cycle pulse coincident with each clk_out rising edge
//   busy       divider running or draining its last period
//   err        one-cycle pulse when an illegal ratio (0 or 1) is accepted
//   cur_div    ratio currently in effect
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_reg,   state_next;
    logic [WIDTH-1:0] cnt_reg,     cnt_next;
    logic [WIDTH-1:0] cur_div_reg, cur_div_next;
    logic [WIDTH-1:0] pend_div_reg, pend_div_next;
    logic             pend_vld_reg, pend_vld_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg,    tick_next;
    logic             err_reg,     err_next;

    // Derived per-cycle values.
    logic [WIDTH-1:0] hi_len;       // high-phase length, ceiling half of N
    logic [WIDTH-1:0] cnt_plus;     // cannot wrap: cnt < cur_div <= 2^WIDTH-1
    logic             at_boundary;  // last cycle of the current period
    logic             cfg_xfer;
    logic             cfg_legal;

    assign hi_len      = cur_div_reg - (cur_div_reg >> 1);
    assign cnt_plus    = cnt_reg + WIDTH'(1);
    assign at_boundary = (cnt_reg == (cur_div_reg - WIDTH'(1)));
    assign cfg_ready   = !pend_vld_reg;
    assign cfg_xfer    = cfg_valid && cfg_ready;
    assign cfg_legal   = (cfg_div >= WIDTH'(2));

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            cur_div_reg  <= WIDTH'(DEFAULT_DIV);
            pend_div_reg <= WIDTH'(DEFAULT_DIV);
            pend_vld_reg <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cur_div_reg  <= cur_div_next;
            pend_div_reg <= pend_div_next;
            pend_vld_reg <= pend_vld_next;
            clk_out_reg  <= clk_out_next;
            tick_reg     <= tick_next;
            err_reg      <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cur_div_next  = cur_div_reg;
        pend_div_next = pend_div_reg;
        pend_vld_next = pend_vld_reg;
        clk_out_next  = 1'b0;
        tick_next     = 1'b0;
        // An illegal ratio still completes the handshake; it only flags err.
        err_next      = cfg_xfer && !cfg_legal;

        case (state_reg)
            IDLE: begin
                // Nothing is being divided, so a new ratio can take effect now.
                if (cfg_xfer && cfg_legal) begin
                    cur_div_next = cfg_div;
                end
                if (en) begin
                    state_next   = RUN;
                    cnt_next     = '0;
                    clk_out_next = 1'b1;
                    tick_next    = 1'b1;
                end
            end

            RUN, DRAIN: begin
                // While running, a ratio is parked until the next boundary.
                // A transfer only happens when nothing is pending, so this
                // never collides with the pending ratio being applied below.
                if (cfg_xfer && cfg_legal) begin
                    pend_div_next = cfg_div;
                    pend_vld_next = 1'b1;
                end

                if (at_boundary) begin
                    cnt_next = '0;
                    if (pend_vld_reg) begin
                        cur_div_next  = pend_div_reg;
                        pend_vld_next = 1'b0;
                    end
                    // DRAIN ignores en: the last period always ends in IDLE.
                    if ((state_reg == RUN) && en) begin
                        clk_out_next = 1'b1;
                        tick_next    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next     = cnt_plus;
                    clk_out_next = (cnt_plus < hi_len);
                    if ((state_reg == RUN) && !en) begin
                        state_next = DRAIN;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;
    assign err     = err_reg;
    assign busy    = (state_reg != IDLE);
    assign cur_div = cur_div_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Self-checking bench for clk_div_ctrl. A table of per-cycle vectors (inputs
// applied before an edge, expected outputs just after it) covers divide-by-4,
// odd divide, live reconfiguration, illegal ratios, drain/stop and a ratio
// offered on a boundary edge. Hand-written sequences cover the asynchronous
// reset in the high phase, rise-to-rise period measurement and stop timing.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             err;
    logic [WIDTH-1:0] cur_div;

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .err      (err),
        .cur_div  (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic             cv;
        logic [WIDTH-1:0] cd;
        logic             x_clk;
        logic             x_tick;
        logic             x_busy;
        logic             x_rdy;
        logic             x_err;
        logic [WIDTH-1:0] x_cur;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic en_i, input logic cv_i, input int cd_i,
                              input logic c_i, input logic t_i, input logic b_i,
                              input logic r_i, input logic e_i, input int cur_i);
        vec_t x;
        x.en     = en_i;
        x.cv     = cv_i;
        x.cd     = WIDTH'(cd_i);
        x.x_clk  = c_i;
        x.x_tick = t_i;
        x.x_busy = b_i;
        x.x_rdy  = r_i;
        x.x_err  = e_i;
        x.x_cur  = WIDTH'(cur_i);
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one master clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int rise_cyc[$];
    logic prev_clk;

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // ---------------- vector table ----------------
        //  en cv cd   clk tick busy rdy err cur
        // divide by 4
        v(1, 0, 0,   1, 1, 1, 1, 0, 4);
        v(1, 0, 0,   1, 0, 1, 1, 0, 4);
        v(1, 0, 0,   0, 0, 1, 1, 0, 4);
        v(1, 0, 0,   0, 0, 1, 1, 0, 4);
        v(1, 0, 0,   1, 1, 1, 1, 0, 4);
        // illegal ratio 1 while running: err pulse, period stays 4
        v(1, 1, 1,   1, 0, 1, 1, 1, 4);
        v(1, 0, 0,   0, 0, 1, 1, 0, 4);
        v(1, 0, 0,   0, 0, 1, 1, 0, 4);
        v(1, 0, 0,   1, 1, 1, 1, 0, 4);
        // live reconfig to 6 offered at cnt=1
        v(1, 0, 0,   1, 0, 1, 1, 0, 4);
        v(1, 1, 6,   0, 0, 1, 0, 0, 4);
        v(1, 0, 0,   0, 0, 1, 0, 0, 4);
        v(1, 0, 0,   1, 1, 1, 1, 0, 6);
        v(1, 0, 0,   1, 0, 1, 1, 0, 6);
        v(1, 0, 0,   1, 0, 1, 1, 0, 6);
        v(1, 0, 0,   0, 0, 1, 1, 0, 6);
        v(1, 0, 0,   0, 0, 1, 1, 0, 6);
        v(1, 0, 0,   0, 0, 1, 1, 0, 6);
        v(1, 0, 0,   1, 1, 1, 1, 0, 6);
        // drop en at cnt=0 -> drain the 6-cycle period; en blip ignored
        v(0, 0, 0,   1, 0, 1, 1, 0, 6);
        v(0, 0, 0,   1, 0, 1, 1, 0, 6);
        v(1, 0, 0,   0, 0, 1, 1, 0, 6);
        v(0, 0, 0,   0, 0, 1, 1, 0, 6);
        v(0, 0, 0,   0, 0, 1, 1, 0, 6);
        v(0, 0, 0,   0, 0, 0, 1, 0, 6);
        v(0, 0, 0,   0, 0, 0, 1, 0, 6);
        // idle reconfig to 5, odd divide 1,1,1,0,0
        v(0, 1, 5,   0, 0, 0, 1, 0, 5);
        v(1, 0, 0,   1, 1, 1, 1, 0, 5);
        v(1, 0, 0,   1, 0, 1, 1, 0, 5);
        v(1, 0, 0,   1, 0, 1, 1, 0, 5);
        v(1, 0, 0,   0, 0, 1, 1, 0, 5);
        v(1, 0, 0,   0, 0, 1, 1, 0, 5);
        v(1, 0, 0,   1, 1, 1, 1, 0, 5);
        v(0, 0, 0,   1, 0, 1, 1, 0, 5);
        v(0, 0, 0,   1, 0, 1, 1, 0, 5);
        v(0, 0, 0,   0, 0, 1, 1, 0, 5);
        v(0, 0, 0,   0, 0, 1, 1, 0, 5);
        v(0, 0, 0,   0, 0, 0, 1, 0, 5);
        // back to 4, then a ratio offered exactly on a boundary edge
        v(0, 1, 4,   0, 0, 0, 1, 0, 4);
        v(1, 0, 0,   1, 1, 1, 1, 0, 4);
        v(1, 0, 0,   1, 0, 1, 1, 0, 4);
        v(1, 0, 0,   0, 0, 1, 1, 0, 4);
        v(1, 0, 0,   0, 0, 1, 1, 0, 4);
        v(1, 1, 3,   1, 1, 1, 0, 0, 4);
        v(1, 0, 0,   1, 0, 1, 0, 0, 4);
        v(1, 0, 0,   0, 0, 1, 0, 0, 4);
        v(1, 0, 0,   0, 0, 1, 0, 0, 4);
        v(1, 0, 0,   1, 1, 1, 1, 0, 3);
        // N=3: 1,1,0; illegal ratio 0 flags err
        v(1, 1, 0,   1, 0, 1, 1, 1, 3);
        v(1, 0, 0,   0, 0, 1, 1, 0, 3);
        // leave a ratio pending for the reset test
        v(1, 1, 7,   1, 1, 1, 0, 0, 3);

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset.clk_out",   clk_out,   0);
        chk("reset.tick",      tick,      0);
        chk("reset.busy",      busy,      0);
        chk("reset.cfg_ready", cfg_ready, 1);
        chk("reset.err",       err,       0);
        chk("reset.cur_div",   cur_div,   4);
        rst = 1'b0;
        step();
        chk("post_reset.clk_out", clk_out, 0);
        chk("post_reset.busy",    busy,    0);
        chk("post_reset.cur_div", cur_div, 4);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            en        = vecs[i].en;
            cfg_valid = vecs[i].cv;
            cfg_div   = vecs[i].cd;
            step();
            $display("vec %0d en=%0b cv=%0b cd=%0d -> clk_out=%0b tick=%0b busy=%0b rdy=%0b err=%0b cur=%0d",
                     i, vecs[i].en, vecs[i].cv, vecs[i].cd, clk_out, tick, busy, cfg_ready, err, cur_div);
            chk($sformatf("vec%0d.clk_out", i),   clk_out,   vecs[i].x_clk);
            chk($sformatf("vec%0d.tick", i),      tick,      vecs[i].x_tick);
            chk($sformatf("vec%0d.busy", i),      busy,      vecs[i].x_busy);
            chk($sformatf("vec%0d.cfg_ready", i), cfg_ready, vecs[i].x_rdy);
            chk($sformatf("vec%0d.err", i),       err,       vecs[i].x_err);
            chk($sformatf("vec%0d.cur_div", i),   cur_div,   vecs[i].x_cur);
        end
        cfg_valid = 1'b0;

        // ---------------- async reset in the high phase ----------------
        chk("arst.pre_clk_out", clk_out, 1);
        rst = 1'b1;
        #2;  // still well before the next clock edge
        chk("arst.clk_out",   clk_out,   0);
        chk("arst.busy",      busy,      0);
        chk("arst.cfg_ready", cfg_ready, 1);
        chk("arst.cur_div",   cur_div,   4);
        $display("arst: clk_out=%0b busy=%0b rdy=%0b cur=%0d", clk_out, busy, cfg_ready, cur_div);
        en = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("arst.idle_clk_out", clk_out, 0);

        // ---------------- divide-by-4 period measurement ----------------
        en = 1'b1;
        prev_clk = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            $display("meas %0d clk_out=%0b tick=%0b", i, clk_out, tick);
            chk($sformatf("meas%0d.clk_out", i), clk_out, ((i % 4) < 2) ? 1 : 0);
            chk($sformatf("meas%0d.tick", i),    tick,    ((i % 4) == 0) ? 1 : 0);
            if (clk_out && !prev_clk) rise_cyc.push_back(i);
            prev_clk = clk_out;
        end
        chk("meas.rise_count", rise_cyc.size(), 4);
        if (rise_cyc.size() >= 2)
            chk("meas.rise_interval", rise_cyc[1] - rise_cyc[0], 4);

        // ---------------- stop at cnt=1 of N=4 ----------------
        step();  // cnt=1
        chk("stop.cnt1_clk_out", clk_out, 1);
        en = 1'b0;
        step();  // cnt=2, draining
        chk("stop.drain_clk_out", clk_out, 0);
        chk("stop.drain_busy",    busy,    1);
        step();  // cnt=3
        chk("stop.last_busy", busy, 1);
        step();  // boundary -> IDLE
        $display("stop: clk_out=%0b tick=%0b busy=%0b", clk_out, tick, busy);
        chk("stop.idle_clk_out", clk_out, 0);
        chk("stop.idle_tick",    tick,    0);
        chk("stop.idle_busy",    busy,    0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("stop.hold%0d.tick", i),    tick,    0);
            chk($sformatf("stop.hold%0d.clk_out", i), clk_out, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
